// File: rtl/video_fetch_sched.sv
// Video RAM slot scheduler: raster timing, shifter word fetches and CPU access
// arbitration on a single RAM port, all outputs registered one cycle after decode.
`timescale 1ns/1ps
module video_fetch_sched #(
    parameter int H_SLOTS     = 256,
    parameter int V_LINES     = 313,
    parameter int H_SLOTS_HI  = 112,
    parameter int V_LINES_HI  = 501,
    parameter int H_START     = 40,
    parameter int V_START     = 50,
    parameter int V_ACTIVE    = 200,
    parameter int V_ACTIVE_HI = 400,
    parameter int WORDS       = 80,
    parameter int WORDS_HI    = 40,
    parameter int HS_LEN      = 16,
    parameter int VS_LEN      = 3
) (
    input  logic        CLOCK_32,
    input  logic        reset,
    input  logic [1:0]  resolution,
    input  logic [21:0] base_addr,
    input  logic        cpu_req,
    input  logic [21:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        cpu_ack,
    output logic        ram_req,
    output logic        ram_we,
    output logic [21:0] ram_addr,
    output logic        ram_src,
    output logic        load,
    output logic        de,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [8:0] H_LAST    = 9'(H_SLOTS - 1);
    localparam logic [8:0] H_LAST_HI = 9'(H_SLOTS_HI - 1);
    localparam logic [8:0] V_LAST    = 9'(V_LINES - 1);
    localparam logic [8:0] V_LAST_HI = 9'(V_LINES_HI - 1);
    localparam logic [8:0] H_FIRST   = 9'(H_START);
    localparam logic [8:0] H_END     = 9'(H_START + WORDS);
    localparam logic [8:0] H_END_HI  = 9'(H_START + WORDS_HI);
    localparam logic [8:0] V_FIRST   = 9'(V_START);
    localparam logic [8:0] V_END     = 9'(V_START + V_ACTIVE);
    localparam logic [8:0] V_END_HI  = 9'(V_START + V_ACTIVE_HI);
    localparam logic [8:0] HS_END    = 9'(HS_LEN);
    localparam logic [8:0] VS_END    = 9'(VS_LEN);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CPU,
        OWN_VIDEO
    } owner_t;

    logic [2:0]  sc;
    logic [8:0]  h_slot;
    logic [8:0]  line;
    logic        mono;
    logic [21:0] vid_addr;
    logic        cpu_busy;

    logic [8:0]  h_last;
    logic [8:0]  v_last;
    logic [8:0]  h_end;
    logic [8:0]  v_end;
    logic        line_active;
    logic        fetch_slot;
    logic        video_phase;
    logic        phase_start;
    logic        frame_start;
    logic        cpu_serve;
    owner_t      owner;

    logic        nxt_ack;
    logic        nxt_req;
    logic        nxt_we;
    logic [21:0] nxt_addr;
    logic        nxt_src;
    logic        nxt_load;
    logic        nxt_de;

    // Geometry of the current frame; mode only changes at frame start so these are stable per frame.
    always_comb begin
        h_last      = mono ? H_LAST_HI : H_LAST;
        v_last      = mono ? V_LAST_HI : V_LAST;
        h_end       = mono ? H_END_HI : H_END;
        v_end       = mono ? V_END_HI : V_END;
        line_active = (line >= V_FIRST) && (line < v_end);
        fetch_slot  = line_active && (h_slot >= H_FIRST) && (h_slot < h_end);
        video_phase = fetch_slot && !sc[2];
        phase_start = (sc[1:0] == 2'd0);
        frame_start = (sc == 3'd0) && (h_slot == 9'd0) && (line == 9'd0);
        cpu_serve   = !video_phase && (phase_start ? cpu_req : cpu_busy);
    end

    // Video owns phase V of a fetch slot; otherwise a CPU request seen at the phase start owns the phase.
    always_comb begin
        owner    = OWN_IDLE;
        nxt_ack  = 1'b0;
        nxt_req  = 1'b0;
        nxt_we   = 1'b0;
        nxt_addr = '0;
        nxt_src  = 1'b0;
        nxt_load = 1'b0;
        nxt_de   = line_active && (h_slot >= H_FIRST) && (h_slot <= h_end);
        if (video_phase) begin
            owner = OWN_VIDEO;
        end else if (cpu_serve) begin
            owner = OWN_CPU;
        end
        case (owner)
            OWN_VIDEO: begin
                nxt_req  = 1'b1;
                nxt_src  = 1'b1;
                nxt_addr = vid_addr;
                nxt_load = sc[1];
            end
            OWN_CPU: begin
                nxt_req  = 1'b1;
                nxt_addr = cpu_addr;
                nxt_we   = !cpu_rw;
                nxt_ack  = (sc[1:0] == 2'd3);
            end
            default: begin
                nxt_req = 1'b0;
            end
        endcase
    end

    // Raster counters, per-frame mode/address latch, and the CPU phase ownership flag.
    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            sc       <= '0;
            h_slot   <= '0;
            line     <= '0;
            mono     <= 1'b0;
            vid_addr <= '0;
            cpu_busy <= 1'b0;
        end else begin
            sc <= sc + 3'd1;
            if (sc == 3'd7) begin
                if (h_slot == h_last) begin
                    h_slot <= '0;
                    line   <= (line == v_last) ? 9'd0 : line + 9'd1;
                end else begin
                    h_slot <= h_slot + 9'd1;
                end
            end
            if (frame_start) begin
                mono     <= (resolution == 2'd2);
                vid_addr <= base_addr;
            end else if (video_phase && (sc == 3'd3)) begin
                vid_addr <= vid_addr + 22'd1;
            end
            if (phase_start) begin
                cpu_busy <= cpu_serve;
            end
        end
    end

    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            cpu_ack  <= 1'b0;
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_src  <= 1'b0;
            load     <= 1'b0;
            de       <= 1'b0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
        end else begin
            cpu_ack  <= nxt_ack;
            ram_req  <= nxt_req;
            ram_we   <= nxt_we;
            ram_addr <= nxt_addr;
            ram_src  <= nxt_src;
            load     <= nxt_load;
            de       <= nxt_de;
            hsync    <= (h_slot < HS_END);
            vsync    <= (line < VS_END);
        end
    end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Bench for video_fetch_sched: a frame-position reference model predicts every output each cycle,
// and per-scenario tasks check the headline counts, addresses and latencies.
`timescale 1ns/1ps
module tb_video_fetch_sched;

    localparam int H_SLOTS     = 256;
    localparam int H_SLOTS_HI  = 112;
    localparam int H_START     = 40;
    localparam int WORDS       = 80;
    localparam int WORDS_HI    = 40;
    localparam int HS_LEN      = 16;
    // Short frames keep a full colour and mono frame within a few tens of thousands of cycles.
    localparam int V_LINES     = 6;
    localparam int V_LINES_HI  = 8;
    localparam int V_START     = 3;
    localparam int V_ACTIVE    = 2;
    localparam int V_ACTIVE_HI = 4;
    localparam int VS_LEN      = 2;

    logic        CLOCK_32 = 1'b0;
    logic        reset;
    logic [1:0]  resolution;
    logic [21:0] base_addr;
    logic        cpu_req;
    logic [21:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_ack;
    logic        ram_req;
    logic        ram_we;
    logic [21:0] ram_addr;
    logic        ram_src;
    logic        load;
    logic        de;
    logic        hsync;
    logic        vsync;

    typedef struct packed {
        logic        ack;
        logic        req;
        logic        we;
        logic [21:0] addr;
        logic        src;
        logic        ld;
        logic        de;
        logic        hs;
        logic        vs;
    } out_t;

    out_t        act;
    out_t        exp_o;
    int          checks = 0;
    int          errors = 0;
    int          m_p;
    bit          m_mode;
    logic [21:0] m_vid;
    bit          m_serve;
    int          mism;
    int          mism_cycle;
    out_t        mism_got;
    out_t        mism_need;
    int          cyc = 0;
    bit          cpu_rand;

    assign act = {cpu_ack, ram_req, ram_we, ram_addr, ram_src, load, de, hsync, vsync};

    video_fetch_sched #(
        .H_SLOTS(H_SLOTS), .V_LINES(V_LINES), .H_SLOTS_HI(H_SLOTS_HI), .V_LINES_HI(V_LINES_HI),
        .H_START(H_START), .V_START(V_START), .V_ACTIVE(V_ACTIVE), .V_ACTIVE_HI(V_ACTIVE_HI),
        .WORDS(WORDS), .WORDS_HI(WORDS_HI), .HS_LEN(HS_LEN), .VS_LEN(VS_LEN)
    ) dut (
        .CLOCK_32(CLOCK_32), .reset(reset), .resolution(resolution), .base_addr(base_addr),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_ack(cpu_ack),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_src(ram_src),
        .load(load), .de(de), .hsync(hsync), .vsync(vsync)
    );

    always #5 CLOCK_32 = ~CLOCK_32;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running need finished");
        $fatal(1, "[TB] watchdog");
    end

    // One clock: predict this cycle's registered outputs from the frame position, then compare after the edge.
    task automatic tick();
        out_t e;
        int   hs, vl, va, w, ln, hh, sc;
        bit   act_line, fetch;
        e = '0;
        if (reset) begin
            m_p = 0; m_mode = 0; m_vid = '0; m_serve = 0;
        end else begin
            if (m_p == 0) begin
                m_mode = (resolution == 2'd2);
                m_vid  = base_addr;
            end
            hs = m_mode ? H_SLOTS_HI : H_SLOTS;
            vl = m_mode ? V_LINES_HI : V_LINES;
            va = m_mode ? V_ACTIVE_HI : V_ACTIVE;
            w  = m_mode ? WORDS_HI : WORDS;
            ln = m_p / (hs * 8);
            hh = (m_p / 8) % hs;
            sc = m_p % 8;
            act_line = (ln >= V_START) && (ln < V_START + va);
            fetch    = act_line && (hh >= H_START) && (hh < H_START + w);
            e.de = act_line && (hh >= H_START) && (hh <= H_START + w);
            e.hs = (hh < HS_LEN);
            e.vs = (ln < VS_LEN);
            if (fetch && sc < 4) begin
                e.req = 1; e.src = 1; e.addr = m_vid; e.ld = (sc >= 2);
                if (sc == 3) m_vid = m_vid + 22'd1;
            end else begin
                if (sc % 4 == 0) m_serve = cpu_req;
                if (m_serve) begin
                    e.req = 1; e.addr = cpu_addr; e.we = !cpu_rw; e.ack = (sc % 4 == 3);
                end
            end
            m_p++;
            if (m_p == hs * 8 * vl) m_p = 0;
        end
        exp_o = e;
        @(posedge CLOCK_32);
        #1;
        if (act !== e) begin
            if (mism == 0) begin
                mism_cycle = cyc; mism_got = act; mism_need = e;
            end
            mism++;
        end
        cyc++;
        if (cpu_rand) begin
            if (cpu_req && exp_o.ack) begin
                cpu_req  = 1'($urandom_range(0, 1));
                cpu_addr = 22'($urandom);
                cpu_rw   = 1'($urandom_range(0, 1));
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req  = 1'b1;
                cpu_addr = 22'($urandom);
                cpu_rw   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic reset_dut();
        cpu_rand = 0;
        cpu_req  = 0;
        reset    = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        mism = 0;
        reset = 1; cpu_req = 1; cpu_rw = 0; cpu_addr = 22'h155555; resolution = 2'd2;
        base_addr = 22'($urandom);
        tick(); tick(); tick();
        checks++; if (ram_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_req: got %b need 0", ram_req); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_ack: got %b need 0", cpu_ack); end
        checks++; if (ram_addr !== 22'd0) begin errors++; $display("[TB] FAIL reset_ram_addr: got %h need 0", ram_addr); end
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %b need 0", load); end
        checks++; if ({de, hsync, vsync} !== 3'b000) begin errors++; $display("[TB] FAIL reset_sync: got %b need 000", {de, hsync, vsync}); end
        cpu_req = 0; resolution = 2'd0; reset = 0;
        tick();
        checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("[TB] FAIL frame_start_sync: got %b need 11", {hsync, vsync}); end
        checks++; if (ram_req !== 1'b0) begin errors++; $display("[TB] FAIL frame_start_idle: got %b need 0", ram_req); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_reset: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_cpu_write();
        int acks = 0, last_ack = 0, bad_gap = 0, req_cyc = 0, bad = 0;
        reset_dut();
        mism = 0;
        cpu_req = 1; cpu_rw = 0; cpu_addr = 22'($urandom);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (ram_req === 1'b1) begin
                req_cyc++;
                if (ram_src !== 1'b0 || ram_we !== 1'b1 || ram_addr !== cpu_addr) bad++;
            end
            if (cpu_ack === 1'b1) begin
                acks++;
                if (i - last_ack != 4) bad_gap++;
                last_ack = i;
            end
        end
        cpu_req = 0;
        tick(); tick(); tick(); tick();
        checks++; if (acks !== 16) begin errors++; $display("[TB] FAIL cpu_write_acks: got %0d need 16", acks); end
        checks++; if (bad_gap !== 0) begin errors++; $display("[TB] FAIL cpu_write_ack_spacing: got %0d irregular need 0", bad_gap); end
        checks++; if (req_cyc !== 64) begin errors++; $display("[TB] FAIL cpu_write_busy: got %0d cycles need 64", req_cyc); end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL cpu_write_fields: got %0d bad cycles need 0", bad); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_cpu_write: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_cpu_in_fetch();
        int target = (V_START * H_SLOTS + H_START + 5) * 8;
        int vid_ok = 0, cpu_ok = 0, ack_at = 0;
        reset_dut();
        mism = 0; base_addr = 22'h001000;
        for (int i = 0; i < 20000 && m_p != target; i++) tick();
        checks++; if (m_p !== target) begin errors++; $display("[TB] FAIL fetch_slot_reach: got pos %0d need %0d", m_p, target); end
        cpu_req = 1; cpu_rw = 1; cpu_addr = 22'h12345;
        for (int i = 1; i <= 12 && ack_at == 0; i++) begin
            tick();
            if (i <= 4) begin
                if (ram_req === 1'b1 && ram_src === 1'b1) vid_ok++;
            end else if (i <= 8) begin
                if (ram_req === 1'b1 && ram_src === 1'b0 && ram_we === 1'b0 && ram_addr === 22'h12345) cpu_ok++;
            end
            if (cpu_ack === 1'b1) begin
                ack_at = i;
                cpu_req = 0;
            end
        end
        cpu_req = 0;
        tick(); tick();
        checks++; if (vid_ok !== 4) begin errors++; $display("[TB] FAIL fetch_phase_video: got %0d need 4", vid_ok); end
        checks++; if (cpu_ok !== 4) begin errors++; $display("[TB] FAIL fetch_phase_cpu: got %0d need 4", cpu_ok); end
        checks++; if (ack_at !== 8) begin errors++; $display("[TB] FAIL fetch_cpu_ack_latency: got %0d need 8", ack_at); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_cpu_in_fetch: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_colour_line();
        logic [21:0] base, first_a, last_a;
        int loads = 0, de_cyc = 0, vid_cyc = 0;
        bit seen = 0, prev_load = 0;
        base = 22'($urandom_range(0, 32'h3FFF00));
        reset_dut();
        mism = 0; base_addr = base; cpu_rand = 1;
        first_a = '0; last_a = '0;
        for (int i = 0; i < (V_START + 1) * H_SLOTS * 8 + 8; i++) begin
            tick();
            if (load === 1'b1 && !prev_load) loads++;
            prev_load = (load === 1'b1);
            if (de === 1'b1) de_cyc++;
            if (ram_req === 1'b1 && ram_src === 1'b1) begin
                vid_cyc++;
                if (!seen) first_a = ram_addr;
                seen = 1;
                last_a = ram_addr;
            end
        end
        cpu_rand = 0; cpu_req = 0;
        checks++; if (loads !== WORDS) begin errors++; $display("[TB] FAIL colour_loads: got %0d need %0d", loads, WORDS); end
        checks++; if (first_a !== base) begin errors++; $display("[TB] FAIL colour_first_addr: got %h need %h", first_a, base); end
        checks++; if (last_a !== base + 22'd79) begin errors++; $display("[TB] FAIL colour_last_addr: got %h need %h", last_a, base + 22'd79); end
        checks++; if (de_cyc !== 648) begin errors++; $display("[TB] FAIL colour_de_cycles: got %0d need 648", de_cyc); end
        checks++; if (vid_cyc !== 320) begin errors++; $display("[TB] FAIL colour_video_cycles: got %0d need 320", vid_cyc); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_colour_line: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_addr_wrap();
        logic [21:0] q[$];
        bit prev_vid = 0;
        reset_dut();
        mism = 0; base_addr = 22'h3FFFF0;
        for (int i = 0; i < (V_START + 1) * H_SLOTS * 8 + 8; i++) begin
            tick();
            if (ram_req === 1'b1 && ram_src === 1'b1 && !prev_vid) q.push_back(ram_addr);
            prev_vid = (ram_req === 1'b1 && ram_src === 1'b1);
        end
        checks++; if (q.size() !== 80) begin errors++; $display("[TB] FAIL wrap_fetch_count: got %0d need 80", q.size()); end
        if (q.size() == 80) begin
            checks++; if (q[15] !== 22'h3FFFFF) begin errors++; $display("[TB] FAIL wrap_fetch16: got %h need 3fffff", q[15]); end
            checks++; if (q[16] !== 22'h000000) begin errors++; $display("[TB] FAIL wrap_fetch17: got %h need 000000", q[16]); end
            checks++; if (q[79] !== 22'd63) begin errors++; $display("[TB] FAIL wrap_fetch80: got %h need 00003f", q[79]); end
        end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_addr_wrap: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_mode_switch();
        int rise[3];
        int rises = 0, last_h = 0, col_hgap = 0, mono_hgap = 0;
        int col_loads = 0, mono_loads = 0, col_de = 0, mono_de = 0;
        bit pv = 0, ph = 0, pl = 0;
        resolution = 2'd0;
        reset_dut();
        mism = 0; base_addr = 22'($urandom); cpu_rand = 1;
        for (int t = 1; t <= 25000 && rises < 3; t++) begin
            tick();
            if (t == 1000) resolution = 2'd2;
            if (hsync === 1'b1 && !ph) begin
                if (rises == 1) col_hgap = t - last_h;
                if (rises == 2) mono_hgap = t - last_h;
                last_h = t;
            end
            if (load === 1'b1 && !pl) begin
                if (rises == 1) col_loads++;
                if (rises == 2) mono_loads++;
            end
            if (de === 1'b1) begin
                if (rises == 1) col_de++;
                if (rises == 2) mono_de++;
            end
            if (vsync === 1'b1 && !pv) begin
                rise[rises] = t;
                rises++;
            end
            ph = (hsync === 1'b1); pl = (load === 1'b1); pv = (vsync === 1'b1);
        end
        cpu_rand = 0; cpu_req = 0; resolution = 2'd0;
        checks++; if (rises !== 3) begin errors++; $display("[TB] FAIL mode_frames_seen: got %0d need 3", rises); end
        if (rises == 3) begin
            checks++; if (rise[1] - rise[0] !== H_SLOTS * 8 * V_LINES) begin errors++; $display("[TB] FAIL mode_colour_frame_len: got %0d need %0d", rise[1] - rise[0], H_SLOTS * 8 * V_LINES); end
            checks++; if (rise[2] - rise[1] !== H_SLOTS_HI * 8 * V_LINES_HI) begin errors++; $display("[TB] FAIL mode_mono_frame_len: got %0d need %0d", rise[2] - rise[1], H_SLOTS_HI * 8 * V_LINES_HI); end
        end
        checks++; if (col_hgap !== H_SLOTS * 8) begin errors++; $display("[TB] FAIL mode_colour_line_len: got %0d need %0d", col_hgap, H_SLOTS * 8); end
        checks++; if (mono_hgap !== H_SLOTS_HI * 8) begin errors++; $display("[TB] FAIL mode_mono_line_len: got %0d need %0d", mono_hgap, H_SLOTS_HI * 8); end
        checks++; if (col_loads !== WORDS * V_ACTIVE) begin errors++; $display("[TB] FAIL mode_colour_loads: got %0d need %0d", col_loads, WORDS * V_ACTIVE); end
        checks++; if (mono_loads !== WORDS_HI * V_ACTIVE_HI) begin errors++; $display("[TB] FAIL mode_mono_loads: got %0d need %0d", mono_loads, WORDS_HI * V_ACTIVE_HI); end
        checks++; if (col_de !== (WORDS + 1) * 8 * V_ACTIVE) begin errors++; $display("[TB] FAIL mode_colour_de: got %0d need %0d", col_de, (WORDS + 1) * 8 * V_ACTIVE); end
        checks++; if (mono_de !== (WORDS_HI + 1) * 8 * V_ACTIVE_HI) begin errors++; $display("[TB] FAIL mode_mono_de: got %0d need %0d", mono_de, (WORDS_HI + 1) * 8 * V_ACTIVE_HI); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_mode_switch: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    task automatic test_reset_mid_cpu();
        int acks = 0;
        reset_dut();
        mism = 0;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 22'h2ABCDE;
        for (int i = 0; i < 40 && m_p != 13; i++) tick();
        checks++; if ({ram_req, ram_src} !== 2'b10) begin errors++; $display("[TB] FAIL midcpu_active: got req/src %b need 10", {ram_req, ram_src}); end
        reset = 1;
        tick();
        checks++; if (act !== '0) begin errors++; $display("[TB] FAIL midcpu_reset_outputs: got %h need 0", act); end
        reset = 0; cpu_req = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL midcpu_no_ack: got %0d acks need 0", acks); end
        checks++; if (mism !== 0) begin errors++; $display("[TB] FAIL model_reset_mid_cpu: %0d bad cycles, first cycle %0d got %h need %h", mism, mism_cycle, mism_got, mism_need); end
    endtask

    initial begin
        reset = 1; resolution = 2'd0; base_addr = '0;
        cpu_req = 0; cpu_addr = '0; cpu_rw = 1; cpu_rand = 0;
        m_p = 0; m_mode = 0; m_vid = '0; m_serve = 0; mism = 0;
        test_reset();
        test_cpu_write();
        test_cpu_in_fetch();
        test_colour_line();
        test_addr_wrap();
        test_mode_switch();
        test_reset_mid_cpu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_fetch_sched.md
# video_fetch_sched

Bus-slot scheduler that sequences the video shifter and shares the single video RAM port between display fetch and CPU accesses. It generates raster timing (hsync, vsync, de), issues one word fetch per video slot inside the active window, and strobes `load` so the shifter latches each word into its input registers. CPU requests are served in the CPU phase of every slot, and in idle video phases.

## Interface
Parameters:
- H_SLOTS, 256: slots per line in colour modes (1 slot = 8 CLOCK_32 cycles).
- V_LINES, 313: lines per frame in colour modes.
- H_SLOTS_HI, 112: slots per line in mono mode.
- V_LINES_HI, 501: lines per frame in mono mode.
- H_START, 40: first fetch slot of a line.
- V_START, 50: first active line; V_START_HI = 50 is shared.
- V_ACTIVE / V_ACTIVE_HI, 200 / 400: active lines.
- WORDS / WORDS_HI, 80 / 40: fetches per active line.
- HS_LEN, 16: hsync width in slots, starting at slot 0.
- VS_LEN, 3: vsync width in lines, starting at line 0.

Ports:
- CLOCK_32  in  1  system clock, 32 MHz.
- reset  in  1  synchronous, active-high.
- resolution  in  2  shifter mode; value 2 selects mono timing.
- base_addr  in  22  frame base word address.
- cpu_req  in  1  level request; held until cpu_ack.
- cpu_addr  in  22  CPU word address.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_req  out  1  RAM cycle active.
- ram_we  out  1  RAM write enable.
- ram_addr  out  22  RAM word address.
- ram_src  out  1  0 = CPU, 1 = video.
- load  out  1  shifter load strobe.
- de  out  1  display enable.
- hsync  out  1  active high.
- vsync  out  1  active high.

## Operation
- Slot counter `sc` counts 0..7 and wraps. Phase V is `sc` 0-3; phase C is `sc` 4-7.
- `h_slot` increments when `sc` = 7 and wraps at the line length. `line` increments on an `h_slot` wrap and wraps at the frame length.
- Mode is latched from `resolution` at frame start (`line` = 0, `h_slot` = 0, `sc` = 0). A mid-frame change has no effect until the next frame.
- At the same frame-start point, `vid_addr` is loaded from `base_addr`.
- A slot is a fetch slot when `line` is in [V_START, V_START + V_ACTIVE) and `h_slot` is in [H_START, H_START + WORDS). The `_HI` values apply in mono mode.

Video cycle, phase V of a fetch slot:
- ram_req = 1, ram_src = 1, ram_we = 0, ram_addr = vid_addr.
- load = 1 on `sc` 2-3.
- vid_addr increments by 1 at `sc` = 3, wrapping modulo 2^22.

CPU cycle, phase C of any slot, or phase V of a non-fetch slot:
- If cpu_req is high at the phase start, drive ram_req = 1, ram_src = 0, ram_addr = cpu_addr, ram_we = !cpu_rw for the 4 cycles.
- cpu_ack = 1 on the phase's last cycle.
- The request is sampled only at a phase start. A request raised mid-phase waits for the next phase.
- A request still high on the cycle after cpu_ack is treated as a new request.

Sync and enable:
- de = 1 from `sc` 0 of the first fetch slot through `sc` 7 of the slot after the last fetch slot. This gives the shifter one trailing slot to drain.
- hsync = 1 while `h_slot` < HS_LEN.
- vsync = 1 while `line` < VS_LEN.
- Video always wins phase V of a fetch slot. CPU never preempts a video cycle.

## Timing
- All outputs are registered; each output changes one cycle after its `sc` decode.
- Reset: all outputs 0; `sc`, `h_slot`, `line` and `vid_addr` are 0; mode = colour.
- The first frame-start occurs in the cycle after reset deasserts.
- Reset asserted mid-cycle aborts the RAM access in that same cycle: ram_req drops and cpu_ack is not issued.
- Worst-case CPU latency from cpu_req to cpu_ack is 12 cycles: a request that just misses a phase start waits 4 cycles, then the 4-cycle phase runs (8), plus boundary alignment.
- load rises exactly 2 cycles after ram_req rises for a video cycle, so the shifter sees a rising edge with data valid.

## Test plan
- Reset, then run 1 colour line with `line` forced active: exactly 80 load pulses; first ram_addr = base_addr; last = base_addr + 79; de high for 81 slots × 8 = 648 cycles.
- cpu_req held with cpu_rw = 0 and no fetch window: ram_src = 0, ram_we = 1, ram_addr = cpu_addr, cpu_ack every 4 cycles.
- cpu_req during a fetch slot: no CPU access in `sc` 0-3; access in `sc` 4-7; cpu_ack at `sc` = 7.
- resolution = 2 written mid-frame: timing unchanged until the next frame; then lines of 112 slots, 40 fetches per line, 501 lines per frame.
- base_addr = 0x3FFFF0 with WORDS = 80: vid_addr wraps to 0 after 16 fetches.
- Reset pulsed during a CPU phase at `sc` = 5: no cpu_ack; all outputs 0 on the next cycle.
